// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants and config record for the programmable clock divider
package clk_div_pkg;
    localparam int DIV_W_DEFAULT = 8;
    localparam logic [DIV_W_DEFAULT-1:0] MIN_DIV = DIV_W_DEFAULT'(2);
    typedef struct packed {
        logic [DIV_W_DEFAULT-1:0] div;
        logic [DIV_W_DEFAULT-1:0] high;
    } div_cfg_t;
endpackage

// File: rtl/clk_div_cfg_shadow.sv
// clk_div_cfg_shadow: stages a requested divider config until the next period boundary
module clk_div_cfg_shadow
    import clk_div_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     load,
    input  div_cfg_t cfg_in,
    input  logic     apply,
    output logic     cfg_pending,
    output logic     cfg_err,
    output div_cfg_t staged
);
    logic ok;
    assign ok = cfg_in.div >= MIN_DIV;
    // last accepted load wins; a load that lands on the apply edge keeps the flag set
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_pending <= 1'b0;
            cfg_err     <= 1'b0;
            staged      <= '0;
        end else begin
            cfg_err <= load && !ok;
            if (load && ok) begin
                staged      <= cfg_in;
                cfg_pending <= 1'b1;
            end else if (apply) begin
                cfg_pending <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/clk_divider_prog.sv
// clk_divider_prog: runtime-programmable divider with glitch-free config switch on period boundaries
module clk_divider_prog
    import clk_div_pkg::*;
#(
    parameter int DIV_W    = DIV_W_DEFAULT,
    parameter int DEF_DIV  = 6,
    parameter int DEF_HIGH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [DIV_W-1:0] cfg_high,
    input  logic             cfg_load,
    output logic             cfg_pending,
    output logic             cfg_err,
    output logic             div_out,
    output logic             tick
);
    logic [DIV_W-1:0] cnt, div_act, high_act;
    logic             wrap, apply;
    div_cfg_t         cfg_req, staged;

    assign cfg_req.div  = DIV_W_DEFAULT'(cfg_div);
    assign cfg_req.high = DIV_W_DEFAULT'(cfg_high);
    assign wrap  = en && (cnt == div_act - DIV_W'(1));
    assign apply = wrap && cfg_pending;

    clk_div_cfg_shadow u_shadow (
        .clk         (clk),
        .reset       (reset),
        .load        (cfg_load),
        .cfg_in      (cfg_req),
        .apply       (apply),
        .cfg_pending (cfg_pending),
        .cfg_err     (cfg_err),
        .staged      (staged)
    );

    // counter, outputs from the pre-edge config, and config swap at the wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            div_act  <= DIV_W'(DEF_DIV);
            high_act <= DIV_W'(DEF_HIGH);
            div_out  <= 1'b0;
            tick     <= 1'b0;
        end else if (en) begin
            div_out <= cnt < high_act;
            tick    <= wrap;
            if (wrap) begin
                cnt <= '0;
                if (cfg_pending) begin
                    div_act  <= DIV_W'(staged.div);
                    high_act <= DIV_W'(staged.high);
                end
            end else begin
                cnt <= cnt + DIV_W'(1);
            end
        end else begin
            tick <= 1'b0;
        end
    end
endmodule

// File: tb/tb_clk_divider_prog.sv
// tb_clk_divider_prog: directed stimulus with a queued scoreboard checked by a monitor
module tb_clk_divider_prog;
    typedef struct {
        logic o, t, p, e;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic [7:0] cfg_div = '0;
    logic [7:0] cfg_high = '0;
    logic       cfg_load = 1'b0;
    logic       cfg_pending, cfg_err, div_out, tick;
    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    clk_divider_prog dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .cfg_div     (cfg_div),
        .cfg_high    (cfg_high),
        .cfg_load    (cfg_load),
        .cfg_pending (cfg_pending),
        .cfg_err     (cfg_err),
        .div_out     (div_out),
        .tick        (tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL cycle %0d %s got %b expected %b", cyc, name, got, want);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (q.size() > 0) begin
            exp_t x;
            x = q.pop_front();
            chk("div_out", div_out, x.o);
            chk("tick", tick, x.t);
            chk("cfg_pending", cfg_pending, x.p);
            chk("cfg_err", cfg_err, x.e);
        end
    end

    task automatic step(input logic r, e, l, input logic [7:0] d, h,
                        input logic eo, et, ep, ee);
        exp_t x;
        reset = r; en = e; cfg_load = l; cfg_div = d; cfg_high = h;
        @(posedge clk);
        x.o = eo; x.t = et; x.p = ep; x.e = ee;
        q.push_back(x);
        @(negedge clk);
    endtask

    task automatic seg(input int d, h, from, to, input logic pend);
        for (int i = from; i < to; i++)
            step(0, 1, 0, 0, 0, i < h, i == d - 1, pend && (i != d - 1), 0);
    endtask

    initial begin
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) seg(6, 3, 0, 6, 0);
        seg(6, 3, 0, 2, 0);
        step(0, 1, 1, 5, 2, 1, 0, 1, 0);
        seg(6, 3, 3, 6, 1);
        repeat (2) seg(5, 2, 0, 5, 0);
        step(0, 1, 1, 4, 1, 1, 0, 1, 0);
        seg(5, 2, 1, 3, 1);
        step(0, 1, 1, 8, 4, 0, 0, 1, 0);
        seg(5, 2, 4, 5, 1);
        seg(8, 4, 0, 8, 0);
        step(0, 1, 1, 6, 2, 1, 0, 1, 0);
        seg(8, 4, 1, 7, 1);
        step(0, 1, 1, 3, 1, 0, 1, 1, 0);
        seg(6, 2, 0, 6, 1);
        repeat (2) seg(3, 1, 0, 3, 0);
        step(0, 1, 1, 1, 5, 1, 0, 0, 1);
        seg(3, 1, 1, 3, 0);
        step(0, 1, 1, 4, 2, 1, 0, 1, 0);
        step(0, 1, 1, 0, 0, 0, 0, 1, 1);
        seg(3, 1, 2, 3, 1);
        seg(4, 2, 0, 2, 0);
        repeat (7) step(0, 0, 0, 0, 0, 1, 0, 0, 0);
        seg(4, 2, 2, 4, 0);
        seg(4, 2, 0, 4, 0);
        step(0, 1, 1, 5, 0, 1, 0, 1, 0);
        seg(4, 2, 1, 4, 1);
        seg(5, 0, 0, 5, 0);
        step(0, 1, 1, 4, 9, 0, 0, 1, 0);
        seg(5, 0, 1, 5, 1);
        repeat (3) seg(4, 9, 0, 4, 0);
        step(0, 1, 1, 7, 2, 1, 0, 1, 0);
        seg(4, 9, 1, 2, 1);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) seg(6, 3, 0, 6, 0);
        repeat (2) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d entries left expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got no finish expected finish before 100000");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/clk_divider_prog.md
Name: clk_divider_prog

Overview:
Runtime-programmable integer clock-enable divider, successor to the fixed divide-by-6 block. Produces a registered divided waveform with programmable ratio and high time, plus a one-cycle period tick. New ratio/high-time values are staged in a shadow register and take effect only on a period boundary, so the output never glitches. It sits in the timing/clock-enable area and feeds LED blinkers, baud ticks and scan strobes.

Parameters:
DIV_W, 8, width of the ratio, high-time and counter fields.
DEF_DIV, 6, divide ratio loaded at reset; legal range 2..2^DIV_W-1.
DEF_HIGH, 3, high time in clk cycles loaded at reset; legal range 0..2^DIV_W-1.

Ports:
clk  in  1  system clock, all logic on rising edge.
reset  in  1  synchronous, active-high reset.
en  in  1  count enable; when low, all state holds.
cfg_div  in  DIV_W  requested divide ratio, sampled on cfg_load.
cfg_high  in  DIV_W  requested high time, sampled on cfg_load.
cfg_load  in  1  one-cycle strobe that stages cfg_div/cfg_high.
cfg_pending  out  1  staged config not yet applied.
cfg_err  out  1  one-cycle pulse: load rejected (cfg_div<2).
div_out  out  1  registered divided waveform.
tick  out  1  one-cycle pulse in the last cycle of each output period.

Behaviour:
- Reset (clk is reset, synchronous, active-high; clock clk):
  - cnt=0, div_act=DEF_DIV, high_act=DEF_HIGH.
  - div_out=0, tick=0, cfg_pending=0, cfg_err=0.
  - Staged config is discarded.
  - Reset mid-period aborts the period immediately.
- Counter:
  - cnt runs 0..div_act-1 and wraps to 0.
  - It advances only when en=1.
  - Wrap condition: cnt==div_act-1 && en.
- Outputs (registered, 1-cycle latency from cnt):
  - On each edge with en=1: div_out <= (cnt < high_act); tick <= wrap.
  - With en=0: div_out holds, tick <= 0.
  - Resulting waveform: high for high_act cycles, then low for div_act-high_act cycles.
  - high_act=0 gives div_out constant 0.
  - high_act>=div_act gives div_out constant 1.
  - tick still pulses once per period in both of these cases.
- Staging:
  - cfg_load with cfg_div>=2: pend_div/pend_high <= inputs, cfg_pending <= 1.
  - A new load while pending overwrites the staged values (last load wins).
  - cfg_load with cfg_div<2: ignored; cfg_err=1 for one cycle; the existing pending state is unchanged.
  - cfg_load is accepted regardless of en.
- Apply:
  - On a wrap edge with cfg_pending=1: div_act/high_act <= staged values, cnt <= 0, cfg_pending <= 0.
  - The div_out/tick values produced on that edge are still computed from the old active config.
- Simultaneous cfg_load and apply on the same edge:
  - The old staged values are applied.
  - The new values are captured into staging.
  - cfg_pending stays 1.
- en low: config is never applied, because no wrap occurs.
- Arithmetic:
  - All compares are unsigned DIV_W-bit.
  - cnt never exceeds div_act-1, because div_act only changes when cnt returns to 0.

Decomposition:
- Package clk_div_pkg:
  - DIV_W_DEFAULT=8.
  - MIN_DIV=2.
  - Typedef div_cfg_t (struct: div, high).
- Sub-module clk_div_cfg_shadow: staging register, pending flag, err pulse, apply handshake (input apply, outputs cfg_pending and staged div_cfg_t).
- Counter and output logic stay in the top module.

Test Plan:
1. Defaults: reset 2 cycles, en=1, run 20 cycles -> div_out sequence 0,1,1,1,0,0,0,1,1,1,0,0,0...; tick high on every 6th cycle, coincident with the third low cycle.
2. Reprogram: mid-period cfg_load cfg_div=5, cfg_high=2 -> current 6-cycle period completes unchanged; cfg_pending=1 until the wrap; then div_out 1,1,0,0,0 repeating.
3. Last-wins and collision:
   - Load (4,1), then (8,4) before the wrap -> only (8,4) is applied.
   - Load (3,1) on the exact wrap edge of a pending config -> pending applied; cfg_pending remains 1; (3,1) applied at the next wrap.
4. Error: cfg_load cfg_div=1 -> cfg_err one-cycle pulse; cfg_pending and waveform unchanged.
5. Enable/edges:
   - en low for 7 cycles mid-period -> div_out and cnt frozen, tick=0; resumes with phase intact.
   - high=0 -> constant 0; high=9 with div=4 -> constant 1, tick every 4 cycles.
6. Reset mid-operation while cfg_pending=1 -> cfg_pending=0, ratio returns to 6/3, next output starts 0,1,1,1.
